// File: rtl/spi_slave_ad5791_rx_pkg.sv
// Shared types and constants for the AD5791 SPI receiver.
// Word layout: bit 23 is R/W, bits 22:20 the register address, bits 19:0 the code.
package spi_ad5791_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    localparam logic [2:0] DAC_REG_ADDR = 3'b001;
    localparam int         RW_BIT       = 23;
    localparam int         CODE_W       = 20;

    function automatic logic is_dac_write(input logic [23:0] w);
        return !w[RW_BIT] && (w[22:20] == DAC_REG_ADDR);
    endfunction

endpackage

// File: rtl/spi_slave_ad5791_rx_if.sv
// AXI-Stream bundle carrying received SPI frames.
interface spi_slave_ad5791_rx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/spi_slave_ad5791_rx_sync.sv
// Multi-flop pin synchronizer that resets to the pin's idle level.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_ad5791_rx.sv
// AD5791 SPI responder: deframes 24-bit words onto AXI-Stream and models the DAC registers.
// Define SPI_RX_CLR_EN to enable the clr_n clear path.
module spi_slave_ad5791_rx
    import spi_ad5791_pkg::*;
#(
    parameter int          DATA_W      = 24,
    parameter int          SYNC_STAGES = 2,
    parameter logic [19:0] CLR_CODE    = 20'h80000
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 sclk,
    input  logic                 sdin,
    input  logic                 sync_n,
    input  logic                 ldac_n,
    input  logic                 clr_n,
    spi_slave_ad5791_rx_if.master m_axis,
    output logic [CODE_W-1:0]    dac_code,
    output logic                 dac_update,
    output logic                 frame_err,
    output logic                 overflow
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

    logic sclk_s, sdin_s, sync_s, ldac_s;
    logic sclk_prev_q, sync_prev_q, ldac_prev_q;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk_i(aclk), .rst_i(areset), .d_i(sclk), .q_o(sclk_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdin (
        .clk_i(aclk), .rst_i(areset), .d_i(sdin), .q_o(sdin_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
        .clk_i(aclk), .rst_i(areset), .d_i(sync_n), .q_o(sync_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ldac (
        .clk_i(aclk), .rst_i(areset), .d_i(ldac_n), .q_o(ldac_s)
    );

    logic clr_act, clr_entry;
`ifdef SPI_RX_CLR_EN
    logic clr_s, clr_prev_q;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
        .clk_i(aclk), .rst_i(areset), .d_i(clr_n), .q_o(clr_s)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) clr_prev_q <= 1'b1;
        else        clr_prev_q <= clr_s;
    end

    assign clr_act   = ~clr_s;
    assign clr_entry = clr_prev_q & ~clr_s;
`else
    logic unused_clr;
    assign unused_clr = clr_n;
    assign clr_act    = 1'b0;
    assign clr_entry  = 1'b0;
`endif

    logic sclk_fall, sync_fall, sync_rise, ldac_fall;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign sync_fall = sync_prev_q & ~sync_s;
    assign sync_rise = ~sync_prev_q & sync_s;
    assign ldac_fall = ldac_prev_q & ~ldac_s;

    rx_state_e         state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sclk_prev_q <= 1'b1;
            sync_prev_q <= 1'b1;
            ldac_prev_q <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            sync_prev_q <= sync_s;
            ldac_prev_q <= ldac_s;
            unique case (state_q)
                ST_IDLE: begin
                    if (sync_fall) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sync_rise) begin
                        state_q <= ST_CHECK;
                    end else if (sclk_fall) begin
                        shift_q <= {shift_q[DATA_W-2:0], sdin_s};
                        if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    logic frame_good, frame_bad, dac_wr;
    assign frame_good = (state_q == ST_CHECK) && (bit_cnt_q == CNT_FULL);
    assign frame_bad  = (state_q == ST_CHECK) && (bit_cnt_q != CNT_FULL);
    assign dac_wr     = is_dac_write(shift_q[23:0]);

    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q, overflow_q, frame_err_q;
    logic [CODE_W-1:0] input_reg_q, dac_code_q;
    logic              dac_update_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            input_reg_q  <= '0;
            dac_code_q   <= '0;
            dac_update_q <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            // A full holding register keeps the old word; the new one is lost.
            if (frame_good) begin
                if (!tvalid_q || m_axis.tready) begin
                    tdata_q  <= shift_q;
                    tvalid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            if (frame_good && dac_wr) input_reg_q <= shift_q[CODE_W-1:0];
            dac_update_q <= 1'b0;
            if (clr_act) begin
                dac_code_q   <= CLR_CODE;
                dac_update_q <= clr_entry;
            end else if (ldac_fall) begin
                dac_code_q   <= input_reg_q;
                dac_update_q <= 1'b1;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign dac_code      = dac_code_q;
    assign dac_update    = dac_update_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_spi_slave_ad5791_rx.sv
// Bench for spi_slave_ad5791_rx: vector table, corner sequences and random frames vs a model.
// Exercises the clear path when SPI_RX_CLR_EN is defined.
module tb_spi_slave_ad5791_rx;
    localparam int SS = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        sclk = 1'b1;
    logic        sdin = 1'b0;
    logic        sync_n = 1'b1;
    logic        ldac_n = 1'b1;
    logic        clr_n = 1'b1;
    logic [19:0] dac_code;
    logic        dac_update, frame_err, overflow;

    spi_slave_ad5791_rx_if #(.DATA_W(24)) axis_if ();

    spi_slave_ad5791_rx #(.DATA_W(24), .SYNC_STAGES(SS)) dut (
        .aclk(aclk), .areset(areset), .sclk(sclk), .sdin(sdin),
        .sync_n(sync_n), .ldac_n(ldac_n), .clr_n(clr_n),
        .m_axis(axis_if), .dac_code(dac_code), .dac_update(dac_update),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0, err_cnt = 0, upd_cnt = 0;
    logic [23:0] hs_last = '0;

    always @(negedge aclk) begin
        if (!areset) begin
            if (axis_if.tvalid && axis_if.tready) begin
                hs_cnt++;
                hs_last = axis_if.tdata;
            end
            if (frame_err) err_cnt++;
            if (dac_update) upd_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // rst_at >= 0 aborts the frame with a reset pulse before that bit
    task automatic send_frame(input logic [23:0] w, input int nbits, input int rst_at);
        sync_n = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                areset = 1'b1;
                sync_n = 1'b1;
                sclk = 1'b1;
                sdin = 1'b0;
                tick(2);
                areset = 1'b0;
                tick(4);
                return;
            end
            sdin = (i < 24) ? w[23-i] : 1'b0;
            tick(2);
            sclk = 1'b0;
            tick(2);
            sclk = 1'b1;
        end
        tick(2);
        sync_n = 1'b1;
    endtask

    task automatic pulse_ldac();
        ldac_n = 1'b0;
        tick(2);
        ldac_n = 1'b1;
        tick(6);
    endtask

    // behavioural DAC model
    logic [19:0] m_input = '0;
    logic [19:0] m_dac = '0;

    function automatic bit is_good(input int nbits);
        return nbits == 24;
    endfunction

    task automatic model_frame(input logic [23:0] w, input int nbits);
        if (is_good(nbits) && w[23] == 1'b0 && w[22:20] == 3'd1) m_input = w[19:0];
    endtask

    task automatic run_frame(input string nm, input logic [23:0] w, input int nbits,
                             input bit ldac, input bit exp_err,
                             input logic [23:0] exp_tdata, input logic [19:0] exp_dac);
        int h0, e0, u0;
        h0 = hs_cnt; e0 = err_cnt; u0 = upd_cnt;
        send_frame(w, nbits, -1);
        tick(10);
        check({nm, ".frame_err"}, err_cnt - e0, exp_err ? 1 : 0);
        check({nm, ".handshakes"}, hs_cnt - h0, exp_err ? 0 : 1);
        if (!exp_err) check({nm, ".tdata"}, hs_last, exp_tdata);
        check({nm, ".tvalid_after"}, axis_if.tvalid, 0);
        if (ldac) begin
            pulse_ldac();
            check({nm, ".dac_update"}, upd_cnt - u0, 1);
        end
        check({nm, ".dac_code"}, dac_code, exp_dac);
    endtask

    typedef struct {
        logic [23:0] word;
        int          nbits;
        bit          ldac;
        bit          exp_err;
        logic [23:0] exp_tdata;
        logic [19:0] exp_dac;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, h0;
        logic [23:0] w;
        int nb, r;
        bit ld;

        vecs[0] = '{24'h1ABCDE, 24, 1'b1, 1'b0, 24'h1ABCDE, 20'hABCDE};
        vecs[1] = '{24'h1ABCDE, 23, 1'b0, 1'b1, 24'h000000, 20'hABCDE};
        vecs[2] = '{24'h155555, 25, 1'b0, 1'b1, 24'h000000, 20'hABCDE};
        vecs[3] = '{24'h900000, 24, 1'b1, 1'b0, 24'h900000, 20'hABCDE};
        vecs[4] = '{24'h112345, 24, 1'b0, 1'b0, 24'h112345, 20'hABCDE};
        vecs[5] = '{24'h200000, 24, 1'b1, 1'b0, 24'h200000, 20'h12345};

        axis_if.tready = 1'b1;
        tick(3);
        check("reset.tvalid", axis_if.tvalid, 0);
        check("reset.dac_code", dac_code, 0);
        check("reset.overflow", overflow, 0);
        check("reset.frame_err", frame_err, 0);
        areset = 1'b0;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].nbits,
                      vecs[i].ldac, vecs[i].exp_err, vecs[i].exp_tdata, vecs[i].exp_dac);
            model_frame(vecs[i].word, vecs[i].nbits);
            if (vecs[i].ldac) m_dac = m_input;
        end

        // backpressure: second frame is dropped, overflow sticks
        axis_if.tready = 1'b0;
        send_frame(24'h100001, 24, -1);
        model_frame(24'h100001, 24);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (lat == 0 && axis_if.tvalid) lat = k;
        end
        check("latency", lat, SS + 2);
        send_frame(24'h100002, 24, -1);
        model_frame(24'h100002, 24);
        tick(10);
        check("bp.tvalid", axis_if.tvalid, 1);
        check("bp.tdata", axis_if.tdata, 24'h100001);
        check("bp.overflow", overflow, 1);
        h0 = hs_cnt;
        axis_if.tready = 1'b1;
        tick(4);
        check("bp.handshakes", hs_cnt - h0, 1);
        check("bp.hs_data", hs_last, 24'h100001);
        check("bp.tvalid_after", axis_if.tvalid, 0);
        check("bp.overflow_sticky", overflow, 1);
        pulse_ldac();
        m_dac = m_input;
        check("bp.dac_code", dac_code, 20'h00002);

        // reset in the middle of a frame, then a clean frame
        send_frame(24'h1FFFFF, 24, 12);
        m_input = '0;
        m_dac = '0;
        check("midrst.overflow", overflow, 0);
        check("midrst.dac_code", dac_code, 0);
        check("midrst.tvalid", axis_if.tvalid, 0);
        run_frame("midrst.frame", 24'h155555, 24, 1'b1, 1'b0, 24'h155555, 20'h55555);
        model_frame(24'h155555, 24);
        m_dac = m_input;

        for (int i = 0; i < 24; i++) begin
            w = 24'($urandom);
            if ($urandom_range(0, 1) == 1) w[23:20] = 4'b0001;
            r = $urandom_range(0, 5);
            nb = (r == 0) ? 23 : (r == 1) ? 25 : 24;
            ld = 1'($urandom_range(0, 1));
            model_frame(w, nb);
            if (ld) m_dac = m_input;
            run_frame($sformatf("rnd%0d", i), w, nb, ld, !is_good(nb), w, m_dac);
        end
        check("rnd.overflow", overflow, 0);

`ifdef SPI_RX_CLR_EN
        h0 = upd_cnt;
        clr_n = 1'b0;
        tick(6);
        check("clr.dac_code", dac_code, 20'h80000);
        check("clr.update", upd_cnt - h0, 1);
        run_frame("clr.frame", 24'h1A5A5A, 24, 1'b0, 1'b0, 24'h1A5A5A, 20'h80000);
        model_frame(24'h1A5A5A, 24);
        ldac_n = 1'b0;
        tick(2);
        ldac_n = 1'b1;
        tick(6);
        check("clr.ldac_ignored", dac_code, 20'h80000);
        clr_n = 1'b1;
        tick(4);
        pulse_ldac();
        check("clr.release_ldac", dac_code, 20'hA5A5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
